// File: rtl/kl10_diag_pkg.sv
// -----------------------------------------------------------------------------
// kl10_diag_pkg
//   Shared definitions for the EBUS diagnostic read path.
//   - DIAG_READ_BASE : 9-bit diagnostic function code for an EDP read. It uses
//                      PDP-10 bit numbering (bit 0 is the MSB). Bits 4..6 are
//                      zero and carry the source selection when driven.
//   - DIAG_SEL_*     : EDP diagnostic source selections (AR..AD).
//   - diag_rd_state_t: state encoding of the diagnostic reader.
// -----------------------------------------------------------------------------
package kl10_diag_pkg;

    localparam logic [0:8] DIAG_READ_BASE = 9'o500;

    localparam logic [2:0] DIAG_SEL_AR  = 3'd0;
    localparam logic [2:0] DIAG_SEL_BR  = 3'd1;
    localparam logic [2:0] DIAG_SEL_MQ  = 3'd2;
    localparam logic [2:0] DIAG_SEL_FM  = 3'd3;
    localparam logic [2:0] DIAG_SEL_BRX = 3'd4;
    localparam logic [2:0] DIAG_SEL_ARX = 3'd5;
    localparam logic [2:0] DIAG_SEL_ADX = 3'd6;
    localparam logic [2:0] DIAG_SEL_AD  = 3'd7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        HOLD  = 2'd2
    } diag_rd_state_t;

endpackage

// File: rtl/diag_ebus_reader.sv
// -----------------------------------------------------------------------------
// diag_ebus_reader
//   Front-end reader for the EBOX EBUS diagnostic read port. A request starts
//   either a single source read or a sweep of all eight EDP sources. For each
//   source the read function is driven for SETTLE_CYCLES cycles, EBUS is
//   captured on the last of them, and the word is offered on a valid/ready
//   response channel.
//
//   Parameter:
//     SETTLE_CYCLES   cycles the read function is held before EBUS is sampled
//                     (legal range 1..15)
//
//   Optional feature:
//     DIAG_PARITY_EN  when defined, adds rspParity (odd parity of rspData,
//                     FM parity convention) captured together with the word.
//
//   Ports:
//     clk, resetN        clock, asynchronous active-low reset
//     reqValid/reqReady  request handshake (reqReady high only in IDLE)
//     reqAll, reqSel     sweep 0..7, or single read of reqSel
//     abortReq           abandon the current operation, no response issued
//     CRAM_DIAG_FUNC     diagnostic function code (bits 4..6 = selection)
//     diagReadFunc12X    enables the data path onto EBUS
//     EBUS               36-bit diagnostic bus
//     rspValid/rspReady  response handshake
//     rspData, rspSel    captured word and the selection that produced it
//     rspLast            final word of the operation
//     busy               an operation is in progress
//     rspParity          odd parity of rspData (DIAG_PARITY_EN only)
// -----------------------------------------------------------------------------
module diag_ebus_reader
    import kl10_diag_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        resetN,

    input  logic        reqValid,
    output logic        reqReady,
    input  logic        reqAll,
    input  logic [2:0]  reqSel,
    input  logic        abortReq,

    output logic [0:8]  CRAM_DIAG_FUNC,
    output logic        diagReadFunc12X,
    input  logic [35:0] EBUS,

    output logic        rspValid,
    input  logic        rspReady,
    output logic [35:0] rspData,
    output logic [2:0]  rspSel,
    output logic        rspLast,
`ifdef DIAG_PARITY_EN
    output logic        rspParity,
`endif
    output logic        busy
);

    localparam logic [3:0] SETTLE_LD = SETTLE_CYCLES[3:0];

    diag_rd_state_t state, state_nxt;

    logic [2:0] sel_q;
    logic       all_q;
    logic [3:0] cnt_q;

    logic       accept;
    logic       capture;
    logic       advance;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state. Abort wins over both capture and the response handshake.
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        capture   = 1'b0;
        advance   = 1'b0;
        unique case (state)
            IDLE: begin
                if (reqValid) begin
                    state_nxt = DRIVE;
                    accept    = 1'b1;
                end
            end
            DRIVE: begin
                if (abortReq) begin
                    state_nxt = IDLE;
                end else if (cnt_q == 4'd1) begin
                    state_nxt = HOLD;
                    capture   = 1'b1;
                end
            end
            HOLD: begin
                if (abortReq) begin
                    state_nxt = IDLE;
                end else if (rspReady) begin
                    if (rspLast) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = DRIVE;
                        advance   = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State-decoded outputs
    // ------------------------------------------------------------------
    assign reqReady        = (state == IDLE);
    assign busy            = (state != IDLE);
    assign diagReadFunc12X = (state == DRIVE);
    assign rspValid        = (state == HOLD);

    always_comb begin
        CRAM_DIAG_FUNC = '0;
        if (state == DRIVE) begin
            CRAM_DIAG_FUNC      = DIAG_READ_BASE;
            CRAM_DIAG_FUNC[4:6] = sel_q;
        end
    end

    // ------------------------------------------------------------------
    // Selection, mode and settle counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            sel_q <= '0;
            all_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            if (accept) begin
                all_q <= reqAll;
                sel_q <= reqAll ? DIAG_SEL_AR : reqSel;
                cnt_q <= SETTLE_LD;
            end else if (advance) begin
                // Sweep never wraps: advance only happens while rspLast=0,
                // i.e. the selection is still below AD.
                sel_q <= sel_q + 3'd1;
                cnt_q <= SETTLE_LD;
            end else if (state == DRIVE) begin
                cnt_q <= cnt_q - 4'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Response capture; held stable through HOLD until the handshake.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            rspData <= '0;
            rspSel  <= '0;
            rspLast <= 1'b0;
        end else if (capture) begin
            rspData <= EBUS;
            rspSel  <= sel_q;
            rspLast <= !all_q || (sel_q == DIAG_SEL_AD);
        end
    end

`ifdef DIAG_PARITY_EN
    // Odd parity: total ones in {rspParity, rspData} is odd; an all-zero
    // word therefore carries parity 1, which is also the reset value.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            rspParity <= 1'b1;
        end else if (capture) begin
            rspParity <= ~^EBUS;
        end
    end
`endif

endmodule

// File: tb/tb_diag_ebus_reader.sv
// -----------------------------------------------------------------------------
// tb_diag_ebus_reader
//   Scoreboard bench for diag_ebus_reader. A small EDP model drives EBUS with
//   the selected source only once the read function has been held for the
//   settle time; otherwise EBUS carries junk. Requests push expected words into
//   a queue; a monitor pops and compares on every response handshake.
// -----------------------------------------------------------------------------
module tb_diag_ebus_reader;
    import kl10_diag_pkg::*;

    localparam int unsigned SETTLE = 4;

    logic        clk = 1'b0;
    logic        resetN = 1'b1;
    logic        reqValid = 1'b0;
    logic        reqReady;
    logic        reqAll = 1'b0;
    logic [2:0]  reqSel = 3'd0;
    logic        abortReq = 1'b0;
    logic [0:8]  CRAM_DIAG_FUNC;
    logic        diagReadFunc12X;
    logic [35:0] EBUS;
    logic        rspValid;
    logic        rspReady = 1'b0;
    logic [35:0] rspData;
    logic [2:0]  rspSel;
    logic        rspLast;
    logic        busy;
`ifdef DIAG_PARITY_EN
    logic        rspParity;
`endif

    diag_ebus_reader #(.SETTLE_CYCLES(SETTLE)) dut (
        .clk             (clk),
        .resetN          (resetN),
        .reqValid        (reqValid),
        .reqReady        (reqReady),
        .reqAll          (reqAll),
        .reqSel          (reqSel),
        .abortReq        (abortReq),
        .CRAM_DIAG_FUNC  (CRAM_DIAG_FUNC),
        .diagReadFunc12X (diagReadFunc12X),
        .EBUS            (EBUS),
        .rspValid        (rspValid),
        .rspReady        (rspReady),
        .rspData         (rspData),
        .rspSel          (rspSel),
        .rspLast         (rspLast),
`ifdef DIAG_PARITY_EN
        .rspParity       (rspParity),
`endif
        .busy            (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
        end
    endfunction

    // ---------------- EDP / EBUS model ----------------
    logic [35:0] edp [8];
    logic [35:0] junk = 36'h5a5a5a5a5;
    logic [5:0]  drv_prev = 6'd0;

    always @(posedge clk or negedge resetN) begin
        if (!resetN) drv_prev <= 6'd0;
        else         drv_prev <= diagReadFunc12X ? drv_prev + 6'd1 : 6'd0;
    end

    always @(negedge clk) junk <= {$urandom, $urandom} & 36'hfffffffff;

    assign EBUS = (diagReadFunc12X && (int'(drv_prev) + 1 >= int'(SETTLE)))
                  ? edp[CRAM_DIAG_FUNC[4:6]] : junk;

    // ---------------- response-ready driver ----------------
    int rdy_prob = 100;

    initial begin
        forever begin
            @(posedge clk);
            #2;
            rspReady = ($urandom_range(99) < rdy_prob);
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [2:0]  sel;
        logic [35:0] data;
        logic        last;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   t_acc = 0;
    bit   first_word = 1'b0;

    logic        prev_valid = 1'b0;
    logic        prev_rdy   = 1'b0;
    logic        prev_abort = 1'b0;
    logic [35:0] prev_data  = '0;
    logic [2:0]  prev_sel   = '0;
    logic        prev_last  = 1'b0;
    bit          after_last = 1'b0;
    int          run = 0;
    logic [0:8]  fn;

    always @(negedge clk) begin
        if (resetN) begin
            if (after_last) chk("ready_after_last", reqReady, 1);
            after_last = 1'b0;

            if (diagReadFunc12X) begin
                run++;
                fn = CRAM_DIAG_FUNC;
                fn[4:6] = 3'b000;
                chk("func_base", fn, DIAG_READ_BASE);
            end else begin
                if (rspValid && !prev_valid) begin
                    chk("settle_len", run, SETTLE);
                    if (first_word) begin
                        chk("latency", cyc - t_acc, SETTLE + 1);
                        first_word = 1'b0;
                    end
                end
                run = 0;
            end

            if (prev_valid && !prev_rdy && !prev_abort) begin
                chk("hold_valid", rspValid, 1);
                chk("hold_data", rspData, prev_data);
                chk("hold_sel", rspSel, prev_sel);
                chk("hold_last", rspLast, prev_last);
            end

            if (rspValid) begin
                chk("hold_func", {diagReadFunc12X, CRAM_DIAG_FUNC}, 0);
                if (sb.size() == 0) begin
                    chk("spurious_rsp", rspValid, 0);
                end else if (rspReady) begin
                    e = sb.pop_front();
                    chk("rsp_sel", rspSel, e.sel);
                    chk("rsp_data", rspData, e.data);
                    chk("rsp_last", rspLast, e.last);
`ifdef DIAG_PARITY_EN
                    chk("rsp_parity", rspParity, ~^e.data);
`endif
                    if (e.last) after_last = 1'b1;
                end
            end
        end else begin
            run = 0;
        end
        prev_valid = rspValid && resetN;
        prev_rdy   = rspReady;
        prev_abort = abortReq;
        prev_data  = rspData;
        prev_sel   = rspSel;
        prev_last  = rspLast;
    end

    // ---------------- stimulus helpers ----------------
    task automatic issue(input bit all, input logic [2:0] sel);
        int n = 0;
        while (!reqReady && n < 200) begin
            @(posedge clk);
            #2;
            n++;
        end
        chk("req_ready_wait", reqReady, 1);
        if (all) begin
            for (int i = 0; i < 8; i++) begin
                sb.push_back('{sel: 3'(i), data: edp[i], last: (i == 7)});
            end
        end else begin
            sb.push_back('{sel: sel, data: edp[sel], last: 1'b1});
        end
        reqAll     = all;
        reqSel     = all ? 3'($urandom) : sel;
        reqValid   = 1'b1;
        t_acc      = cyc;
        first_word = 1'b1;
        @(posedge clk);
        #2;
        reqValid = 1'b0;
        reqAll   = 1'($urandom);
        reqSel   = 3'($urandom);
    endtask

    task automatic wait_done();
        int n = 0;
        while ((sb.size() != 0 || !reqReady) && n < 1000) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (n >= 1000) begin
            chk("op_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int n;
        for (int i = 0; i < 8; i++) edp[i] = '0;
        #1 resetN = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_reqReady", reqReady, 1);
        chk("rst_busy", busy, 0);
        chk("rst_12x", diagReadFunc12X, 0);
        chk("rst_func", CRAM_DIAG_FUNC, 0);
        chk("rst_valid", rspValid, 0);
        chk("rst_data", rspData, 0);
        chk("rst_sel", rspSel, 0);
        chk("rst_last", rspLast, 0);
`ifdef DIAG_PARITY_EN
        chk("rst_parity", rspParity, 1);
`endif
        resetN = 1'b1;
        @(posedge clk);
        #2;

        // single read of ARX
        edp[5] = 36'o123456701234;
        rdy_prob = 100;
        issue(1'b0, 3'd5);
        wait_done();

        // full sweep
        for (int i = 0; i < 8; i++) edp[i] = 36'o1000 + 36'(i);
        issue(1'b1, 3'd0);
        wait_done();

        // backpressure in HOLD
        for (int i = 0; i < 8; i++) edp[i] = {$urandom, $urandom} & 36'hfffffffff;
        rdy_prob = 0;
        @(posedge clk);
        #2;
        issue(1'b1, 3'd0);
        n = 0;
        while (!rspValid && n < 50) begin
            @(posedge clk);
            #2;
            n++;
        end
        chk("bp_reach_hold", rspValid, 1);
        repeat (10) @(posedge clk);
        #2;
        chk("bp_no_drive", diagReadFunc12X, 0);
        chk("bp_still_valid", rspValid, 1);
        rdy_prob = 100;
        wait_done();

        // abort in the second DRIVE cycle of a sweep
        issue(1'b1, 3'd0);
        @(posedge clk);
        #2;
        abortReq = 1'b1;
        @(posedge clk);
        #2;
        abortReq = 1'b0;
        sb.delete();
        first_word = 1'b0;
        chk("abort_idle", reqReady, 1);
        chk("abort_busy", busy, 0);
        chk("abort_12x", diagReadFunc12X, 0);
        repeat (SETTLE + 4) @(posedge clk);
        #2;
        edp[2] = 36'o777000111222;
        issue(1'b0, 3'd2);
        wait_done();

        // reset while holding a sweep word
        rdy_prob = 0;
        @(posedge clk);
        #2;
        issue(1'b1, 3'd0);
        n = 0;
        while (!rspValid && n < 50) begin
            @(posedge clk);
            #2;
            n++;
        end
        chk("rst_reach_hold", rspValid, 1);
        #1;
        resetN = 1'b0;
        #1;
        chk("mrst_valid", rspValid, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_12x", diagReadFunc12X, 0);
        chk("mrst_ready", reqReady, 1);
        chk("mrst_data", rspData, 0);
        sb.delete();
        first_word = 1'b0;
        @(posedge clk);
        #2;
        chk("mrst_ready_low", reqReady, 1);
        resetN = 1'b1;
        rdy_prob = 100;
        @(posedge clk);
        #2;
        chk("mrst_ready_rel", reqReady, 1);
        chk("mrst_busy_rel", busy, 0);

        // parity corner words
        edp[1] = 36'o000000000007;
        issue(1'b0, 3'd1);
        wait_done();
        edp[1] = 36'o0;
        issue(1'b0, 3'd1);
        wait_done();

        // randomized operations
        for (int k = 0; k < 25; k++) begin
            for (int i = 0; i < 8; i++) edp[i] = {$urandom, $urandom} & 36'hfffffffff;
            rdy_prob = $urandom_range(100, 30);
            issue(1'($urandom_range(1)), 3'($urandom_range(7)));
            wait_done();
        end

        rdy_prob = 100;
        repeat (3) @(posedge clk);
        #2;
        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
